// File: rtl/debug_display.sv
`default_nettype none
// ============================================================================
//  Module   : debug_display
//  Purpose  : Snapshots one of four 16-bit debug values and scans it as four
//             hex digits onto a common-anode seven-segment display.
//             Optional macro DEBUG_DISPLAY_LZB_EN enables leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] in_sign1,
    input  logic [15:0] in_sign2,
    input  logic [15:0] in_sign3,
    input  logic [15:0] in_sign4,
    input  logic [1:0]  sel,
    input  logic        freeze,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int c_DIV_W = $clog2(REFRESH_DIV);

    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_idx;
    logic [15:0]        r_snap;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_div_last;
    logic               w_frame_end;
    logic [15:0]        w_sel_val;
    logic [3:0]         w_nib;
    logic [6:0]         w_hex;
    logic [3:0]         w_an_onehot;
    logic               w_blank;

    assign w_div_last  = (r_div == c_DIV_W'(REFRESH_DIV - 1));
    assign w_frame_end = w_div_last && (r_idx == 2'd3);
    assign w_nib       = r_snap[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_sel_val = in_sign1;
        case (sel)
            2'd0:    w_sel_val = in_sign1;
            2'd1:    w_sel_val = in_sign2;
            2'd2:    w_sel_val = in_sign3;
            default: w_sel_val = in_sign4;
        endcase
    end

    always_comb begin
        w_an_onehot        = 4'b1111;
        w_an_onehot[r_idx] = 1'b0;
    end

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    always_comb begin
        w_hex = 7'b1111111;
        case (w_nib)
            4'h0:    w_hex = 7'b1000000;
            4'h1:    w_hex = 7'b1111001;
            4'h2:    w_hex = 7'b0100100;
            4'h3:    w_hex = 7'b0110000;
            4'h4:    w_hex = 7'b0011001;
            4'h5:    w_hex = 7'b0010010;
            4'h6:    w_hex = 7'b0000010;
            4'h7:    w_hex = 7'b1111000;
            4'h8:    w_hex = 7'b0000000;
            4'h9:    w_hex = 7'b0010000;
            4'hA:    w_hex = 7'b0001000;
            4'hB:    w_hex = 7'b0000011;
            4'hC:    w_hex = 7'b1000110;
            4'hD:    w_hex = 7'b0100001;
            4'hE:    w_hex = 7'b0000110;
            default: w_hex = 7'b0001110;
        endcase
    end

`ifdef DEBUG_DISPLAY_LZB_EN
    // A digit blanks only when it and every more-significant nibble are zero
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd0:    w_blank = 1'b0;
            2'd1:    w_blank = (r_snap[15:4]  == 12'h000);
            2'd2:    w_blank = (r_snap[15:8]  == 8'h00);
            default: w_blank = (r_snap[15:12] == 4'h0);
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_div  <= '0;
            r_idx  <= 2'd0;
            r_snap <= 16'h0000;
        end else begin
            r_div <= w_div_last ? '0 : r_div + c_DIV_W'(1);
            if (w_div_last) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_frame_end && !freeze) begin
                r_snap <= w_sel_val;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_blank ? 4'b1111    : w_an_onehot;
            r_seg <= w_blank ? 7'b1111111 : w_hex;
            r_dp  <= ~((r_idx == 2'd0) && freeze);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_debug_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_display
//  Purpose  : Directed self-checking bench for debug_display (REFRESH_DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debug_display;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] in_sign1 = '0;
    logic [15:0] in_sign2 = '0;
    logic [15:0] in_sign3 = '0;
    logic [15:0] in_sign4 = '0;
    logic [1:0]  sel = '0;
    logic        freeze = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] snap_m;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    debug_display #(.REFRESH_DIV(4)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .in_sign1 (in_sign1),
        .in_sign2 (in_sign2),
        .in_sign3 (in_sign3),
        .in_sign4 (in_sign4),
        .sel      (sel),
        .freeze   (freeze),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic blanked(input logic [15:0] v, input int k);
`ifdef DEBUG_DISPLAY_LZB_EN
        if (k == 0) return 1'b0;
        return ((v >> (4 * k)) == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    // Expected outputs for digit slot k of value v with the given freeze level
    function automatic void expect_digit(input logic [15:0] v, input int k, input logic frz);
        logic [15:0] t;
        t = v >> (4 * k);
        e_an    = 4'b1111;
        e_an[k] = 1'b0;
        e_seg   = hex7(t[3:0]);
        if (blanked(v, k)) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
        end
        e_dp = (k == 0 && frz) ? 1'b0 : 1'b1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        #1;
        n_checks++; if (an !== 4'b1111) begin n_errors++; $display("FAIL reset_an got %b want 1111", an); end
        n_checks++; if (seg !== 7'b1111111) begin n_errors++; $display("FAIL reset_seg got %b want 1111111", seg); end
        n_checks++; if (dp !== 1'b1) begin n_errors++; $display("FAIL reset_dp got %b want 1", dp); end
        @(negedge CLK);
        n_checks++; if (an !== 4'b1111) begin n_errors++; $display("FAIL reset_hold_an got %b want 1111", an); end
        n_checks++; if (seg !== 7'b1111111) begin n_errors++; $display("FAIL reset_hold_seg got %b want 1111111", seg); end
        Reset  = 1'b1;
        snap_m = 16'h0000;
    endtask

    task automatic test_scan();
        for (int n = 0; n < 16; n++) begin
            tick();
            expect_digit(snap_m, n / 4, freeze);
            n_checks++; if (an !== e_an) begin n_errors++; $display("FAIL scan_an n=%0d got %b want %b", n, an, e_an); end
            n_checks++; if (seg !== e_seg) begin n_errors++; $display("FAIL scan_seg n=%0d got %b want %b", n, seg, e_seg); end
            n_checks++; if (dp !== e_dp) begin n_errors++; $display("FAIL scan_dp n=%0d got %b want %b", n, dp, e_dp); end
        end
    endtask

    task automatic test_hex_capture();
        in_sign2 = 16'h1234;
        sel      = 2'd1;
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 16; n++) begin
                tick();
                expect_digit(snap_m, n / 4, freeze);
                n_checks++; if (an !== e_an) begin n_errors++; $display("FAIL hex_an f=%0d n=%0d got %b want %b", f, n, an, e_an); end
                n_checks++; if (seg !== e_seg) begin n_errors++; $display("FAIL hex_seg f=%0d n=%0d got %b want %b", f, n, seg, e_seg); end
            end
            snap_m = 16'h1234;
        end
    endtask

    task automatic test_freeze();
        freeze   = 1'b1;
        in_sign2 = 16'hBEEF;
        for (int f = 0; f < 5; f++) begin
            if (f == 3) freeze = 1'b0;
            for (int n = 0; n < 16; n++) begin
                tick();
                expect_digit(snap_m, n / 4, freeze);
                n_checks++; if (an !== e_an) begin n_errors++; $display("FAIL frz_an f=%0d n=%0d got %b want %b", f, n, an, e_an); end
                n_checks++; if (seg !== e_seg) begin n_errors++; $display("FAIL frz_seg f=%0d n=%0d got %b want %b", f, n, seg, e_seg); end
                n_checks++; if (dp !== e_dp) begin n_errors++; $display("FAIL frz_dp f=%0d n=%0d got %b want %b", f, n, dp, e_dp); end
            end
            if (!freeze) snap_m = 16'hBEEF;
        end
    endtask

    task automatic test_sel_change();
        in_sign4 = 16'hA5A5;
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 16; n++) begin
                if (f == 0 && n == 6) sel = 2'd3;
                tick();
                expect_digit(snap_m, n / 4, freeze);
                n_checks++; if (an !== e_an) begin n_errors++; $display("FAIL sel_an f=%0d n=%0d got %b want %b", f, n, an, e_an); end
                n_checks++; if (seg !== e_seg) begin n_errors++; $display("FAIL sel_seg f=%0d n=%0d got %b want %b", f, n, seg, e_seg); end
            end
            snap_m = 16'hA5A5;
        end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 9; n++) begin
            tick();
            expect_digit(snap_m, n / 4, freeze);
            n_checks++; if (seg !== e_seg) begin n_errors++; $display("FAIL pre_rst_seg n=%0d got %b want %b", n, seg, e_seg); end
        end
        #2 Reset = 1'b0;
        #1;
        n_checks++; if (an !== 4'b1111) begin n_errors++; $display("FAIL async_an got %b want 1111", an); end
        n_checks++; if (seg !== 7'b1111111) begin n_errors++; $display("FAIL async_seg got %b want 1111111", seg); end
        Reset    = 1'b1;
        snap_m   = 16'h0000;
        sel      = 2'd0;
        in_sign1 = 16'h0007;
        @(negedge CLK);
        n_checks++; if (an !== 4'b1110) begin n_errors++; $display("FAIL post_rst_an got %b want 1110", an); end
        n_checks++; if (seg !== 7'b1000000) begin n_errors++; $display("FAIL post_rst_seg got %b want 1000000", seg); end
        for (int n = 1; n < 16; n++) begin
            tick();
            expect_digit(snap_m, n / 4, freeze);
            n_checks++; if (an !== e_an) begin n_errors++; $display("FAIL post_rst_an n=%0d got %b want %b", n, an, e_an); end
            n_checks++; if (seg !== e_seg) begin n_errors++; $display("FAIL post_rst_seg n=%0d got %b want %b", n, seg, e_seg); end
        end
        snap_m = 16'h0007;
    endtask

    task automatic test_leading_zeros();
        for (int n = 0; n < 16; n++) begin
            tick();
            expect_digit(snap_m, n / 4, freeze);
            n_checks++; if (an !== e_an) begin n_errors++; $display("FAIL lzb_an n=%0d got %b want %b", n, an, e_an); end
            n_checks++; if (seg !== e_seg) begin n_errors++; $display("FAIL lzb_seg n=%0d got %b want %b", n, seg, e_seg); end
            n_checks++; if (dp !== e_dp) begin n_errors++; $display("FAIL lzb_dp n=%0d got %b want %b", n, dp, e_dp); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_hex_capture();
        test_freeze();
        test_sel_change();
        test_async_reset();
        test_leading_zeros();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
